// File: rtl/ttl_dual_down_counter_pkg.sv
// ---------------------------------------------------------------------------
// ttl_dual_down_counter_pkg
// Shared definitions for the dual presettable down counter.
//   cnt_action_e  : what a counter cell does at the next rising edge
//   select_action : priority resolver Clear > Load > count > hold, with the
//                   count split into decrement / wrap / reload cases
// ---------------------------------------------------------------------------
package ttl_dual_down_counter_pkg;

   typedef enum logic [2:0] {
      ACT_HOLD   = 3'd0,
      ACT_CLEAR  = 3'd1,
      ACT_LOAD   = 3'd2,
      ACT_DEC    = 3'd3,
      ACT_WRAP   = 3'd4,
      ACT_RELOAD = 3'd5
   } cnt_action_e;

   function automatic cnt_action_e select_action(
      input logic clear,
      input logic load,
      input logic en,
      input logic zero,
      input logic reload
   );
      cnt_action_e act;
      act = ACT_HOLD;
      if (clear)
         act = ACT_CLEAR;
      else if (load)
         act = ACT_LOAD;
      else if (en) begin
         if (!zero)
            act = ACT_DEC;
         else if (reload)
            act = ACT_RELOAD;
         else
            act = ACT_WRAP;
      end
      return act;
   endfunction

endpackage

// File: rtl/ttl_down_counter_cell.sv
// ---------------------------------------------------------------------------
// ttl_down_counter_cell
// One WIDTH-bit presettable down counter with zero flag.
//   clk   : rising-edge clock
//   clear : synchronous active-high clear (highest priority)
//   load  : synchronous parallel load from d
//   en    : effective count enable (cascade already resolved by the parent)
//   d     : preset / reload value
//   q     : registered count
//   zero  : q == 0, from the registered count
// When RELOAD=1 a decrement from zero reloads d instead of wrapping to all
// ones, turning the cell into a divide-by-(d+1) counter.
// ---------------------------------------------------------------------------
module ttl_down_counter_cell
   import ttl_dual_down_counter_pkg::*;
#(
   parameter int WIDTH  = 5,
   parameter int RELOAD = 0
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             zero
);

   localparam logic RELOAD_EN = (RELOAD != 0);

   cnt_action_e act;

   assign zero = (q == '0);
   assign act  = select_action(clear, load, en, zero, RELOAD_EN);

   always_ff @(posedge clk) begin
      unique case (act)
         ACT_CLEAR:           q <= '0;
         ACT_LOAD,
         ACT_RELOAD:          q <= d;
         ACT_DEC:             q <= q - WIDTH'(1);
         ACT_WRAP:            q <= '1;
         default:             q <= q;
      endcase
   end

endmodule

// File: rtl/ttl_dual_down_counter.sv
// ---------------------------------------------------------------------------
// ttl_dual_down_counter
// BLOCKS presettable synchronous down counters whose packed counts feed the
// 5-input zero-detect NOR stage (Q_2D maps bit-for-bit onto its A_2D).
//   Clk    : rising-edge clock for all blocks
//   Clear  : synchronous active-high clear of every block
//   Load   : per-block synchronous parallel load from D_2D
//   Enable : per-block count enable
//   D_2D   : packed preset data, block i = [i*WIDTH +: WIDTH]
//   Q_2D   : packed counts, same packing as D_2D
//   BO     : per-block borrow-out = (count==0) & effective enable & ~Clear
// CASCADE=1 chains the blocks: block i only counts while block i-1 borrows,
// giving one BLOCKS*WIDTH-bit counter without ripple clocks.
// ---------------------------------------------------------------------------
module ttl_dual_down_counter
   import ttl_dual_down_counter_pkg::*;
#(
   parameter int BLOCKS     = 2,
   parameter int WIDTH      = 5,
   parameter int CASCADE    = 0,
   parameter int RELOAD     = 0,
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic                    Clk,
   input  logic                    Clear,
   input  logic [BLOCKS-1:0]       Load,
   input  logic [BLOCKS-1:0]       Enable,
   input  logic [BLOCKS*WIDTH-1:0] D_2D,
   output logic [BLOCKS*WIDTH-1:0] Q_2D,
   output logic [BLOCKS-1:0]       BO
);

   logic [WIDTH-1:0]        d_arr [BLOCKS];
   logic [WIDTH-1:0]        q_arr [BLOCKS];
   logic [BLOCKS-1:0]       zero;
   logic [BLOCKS-1:0]       en_eff;
   logic [BLOCKS-1:0]       bo_int;
   logic [BLOCKS*WIDTH-1:0] q_bus;

   // Borrow chain resolved in one block, lowest block first, so each stage
   // sees the finished borrow of the stage below it.
   always_comb begin
      en_eff = '0;
      bo_int = '0;
      for (int i = 0; i < BLOCKS; i++) begin
         if (i == 0 || CASCADE == 0)
            en_eff[i] = Enable[i];
         else
            en_eff[i] = Enable[i] & bo_int[i-1];
         bo_int[i] = zero[i] & en_eff[i] & ~Clear;
      end
   end

   for (genvar g = 0; g < BLOCKS; g++) begin : g_block
      assign d_arr[g] = D_2D[g*WIDTH +: WIDTH];

      ttl_down_counter_cell #(
         .WIDTH  (WIDTH),
         .RELOAD (RELOAD)
      ) u_cell (
         .clk   (Clk),
         .clear (Clear),
         .load  (Load[g]),
         .en    (en_eff[g]),
         .d     (d_arr[g]),
         .q     (q_arr[g]),
         .zero  (zero[g])
      );

      assign q_bus[g*WIDTH +: WIDTH] = q_arr[g];
   end

   assign #(DELAY_RISE, DELAY_FALL) Q_2D = q_bus;
   assign #(DELAY_RISE, DELAY_FALL) BO   = bo_int;

endmodule

// File: tb/tb_ttl_dual_down_counter.sv
module tb_ttl_dual_down_counter;

   localparam int BLOCKS = 2;
   localparam int WIDTH  = 5;

   logic                    Clk = 1'b0;
   logic                    Clear = 1'b0;
   logic [BLOCKS-1:0]       Load = '0;
   logic [BLOCKS-1:0]       Enable = '0;
   logic [BLOCKS*WIDTH-1:0] D_2D = '0;

   logic [BLOCKS*WIDTH-1:0] q_wrap, q_rel, q_cas;
   logic [BLOCKS-1:0]       bo_wrap, bo_rel, bo_cas;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clk = ~Clk;

   ttl_dual_down_counter #(.BLOCKS(BLOCKS), .WIDTH(WIDTH), .CASCADE(0), .RELOAD(0),
                           .DELAY_RISE(0), .DELAY_FALL(0)) dut_wrap (
      .Clk(Clk), .Clear(Clear), .Load(Load), .Enable(Enable), .D_2D(D_2D),
      .Q_2D(q_wrap), .BO(bo_wrap));

   ttl_dual_down_counter #(.BLOCKS(BLOCKS), .WIDTH(WIDTH), .CASCADE(0), .RELOAD(1),
                           .DELAY_RISE(0), .DELAY_FALL(0)) dut_rel (
      .Clk(Clk), .Clear(Clear), .Load(Load), .Enable(Enable), .D_2D(D_2D),
      .Q_2D(q_rel), .BO(bo_rel));

   ttl_dual_down_counter #(.BLOCKS(BLOCKS), .WIDTH(WIDTH), .CASCADE(1), .RELOAD(0),
                           .DELAY_RISE(0), .DELAY_FALL(0)) dut_cas (
      .Clk(Clk), .Clear(Clear), .Load(Load), .Enable(Enable), .D_2D(D_2D),
      .Q_2D(q_cas), .BO(bo_cas));

   // Zero-detect NOR stage driven by Q_2D (block 0 slice).
   logic y0_wrap;
   assign y0_wrap = ~|q_wrap[WIDTH-1:0];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one rising edge and settle away from it.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Hand-computed tables.
   int wrap_q  [4] = '{1, 0, 31, 30};
   int wrap_bo [4] = '{0, 0, 1, 0};   // BO[0] seen with Q0 = 2,1,0,31
   int rel_q   [6] = '{3, 2, 1, 0, 4, 3};
   int rel_bo  [6] = '{0, 0, 0, 0, 1, 0}; // BO[0] seen with Q0 = 4,3,2,1,0,4

   initial begin
      #2;
      // ---------------- Reset ----------------
      D_2D = 10'h3FF; Load = 2'b11; Enable = 2'b00;
      tick();
      check("preload_3ff", 32'(q_wrap), 32'h3FF);
      Load = 2'b00; Enable = 2'b11; Clear = 1'b1;
      #1;
      check("bo_during_clear_wrap", 32'(bo_wrap), 32'h0);
      check("bo_during_clear_cas", 32'(bo_cas), 32'h0);
      tick();
      check("q_after_clear_wrap", 32'(q_wrap), 32'h0);
      check("q_after_clear_cas", 32'(q_cas), 32'h0);
      check("bo_clear_high_at_zero", 32'(bo_wrap), 32'h0);
      Clear = 1'b0; Enable = 2'b00;
      #1;
      check("bo_after_release", 32'(bo_wrap), 32'h0);

      // ---------------- Load ----------------
      D_2D = {5'd3, 5'd17}; Load = 2'b11; Enable = 2'b11;
      tick();
      check("load_no_dec_wrap", 32'(q_wrap), 32'(10'd113));
      check("load_no_dec_rel", 32'(q_rel), 32'(10'd113));
      D_2D = 10'h3FF; Load = 2'b11; Clear = 1'b1;
      tick();
      check("load_plus_clear", 32'(q_wrap), 32'h0);
      Clear = 1'b0; Load = 2'b00; Enable = 2'b00;

      // ---------------- Wrap ----------------
      D_2D = {5'd0, 5'd2}; Load = 2'b01;
      tick();
      check("wrap_loaded", 32'(q_wrap[4:0]), 32'd2);
      Load = 2'b00; Enable = 2'b01;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("wrap_bo_%0d", k), 32'(bo_wrap[0]), 32'(wrap_bo[k]));
         tick();
         check($sformatf("wrap_q_%0d", k), 32'(q_wrap[4:0]), 32'(wrap_q[k]));
         check($sformatf("wrap_y0_%0d", k), 32'(y0_wrap), 32'(wrap_q[k] == 0));
      end
      check("wrap_block1_hold", 32'(q_wrap[9:5]), 32'd0);
      Enable = 2'b00;

      // ---------------- Reload ----------------
      D_2D = {5'd0, 5'd4}; Load = 2'b01;
      tick();
      check("rel_loaded", 32'(q_rel[4:0]), 32'd4);
      Load = 2'b00; Enable = 2'b01;
      for (int k = 0; k < 6; k++) begin
         #1;
         check($sformatf("rel_bo_%0d", k), 32'(bo_rel[0]), 32'(rel_bo[k]));
         tick();
         check($sformatf("rel_q_%0d", k), 32'(q_rel[4:0]), 32'(rel_q[k]));
      end
      Enable = 2'b00;
      D_2D = 10'd0; Load = 2'b01;
      tick();
      Load = 2'b00; Enable = 2'b01;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("rel0_bo_%0d", k), 32'(bo_rel[0]), 32'd1);
         tick();
         check($sformatf("rel0_q_%0d", k), 32'(q_rel[4:0]), 32'd0);
      end
      Enable = 2'b00;

      // ---------------- Cascade ----------------
      D_2D = {5'd5, 5'd1}; Load = 2'b11;
      tick();
      check("cas_loaded", 32'(q_cas), 32'(10'd161));
      Load = 2'b00; Enable = 2'b11;
      #1;
      check("cas_bo_e0", 32'(bo_cas), 32'b00);
      tick();
      check("cas_edge1", 32'(q_cas), 32'(10'd160));
      check("cas_bo_e1", 32'(bo_cas), 32'b01);
      tick();
      check("cas_edge2", 32'(q_cas), 32'(10'd159));
      tick();
      check("cas_edge3", 32'(q_cas), 32'(10'd158));
      Enable = 2'b00; D_2D = 10'd0; Load = 2'b11;
      tick();
      Load = 2'b00; Enable = 2'b11;
      #1;
      check("cas_bo_rollover", 32'(bo_cas), 32'b11);
      tick();
      check("cas_rollover", 32'(q_cas), 32'h3FF);
      check("cas_bo_after_roll", 32'(bo_cas), 32'b00);
      Enable = 2'b00;

      // ---------------- Mid-count Clear + NOR ----------------
      D_2D = {5'd0, 5'd12}; Load = 2'b01;
      tick();
      Load = 2'b00; Enable = 2'b01;
      tick(); tick(); tick();
      check("mid_q9", 32'(q_wrap[4:0]), 32'd9);
      check("mid_y0_low", 32'(y0_wrap), 32'd0);
      Clear = 1'b1;
      #1;
      check("mid_bo_clear", 32'(bo_wrap), 32'h0);
      tick();
      check("mid_q_cleared", 32'(q_wrap[4:0]), 32'd0);
      check("mid_y0_high", 32'(y0_wrap), 32'd1);
      Clear = 1'b0;
      tick();
      check("mid_resume_wrap", 32'(q_wrap[4:0]), 32'd31);
      check("mid_y0_low2", 32'(y0_wrap), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
